rf_wb_arbiter: RTL and testbench
================================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
REQ-002 The block SHALL have three requester ports, i = 0 (ALU), 1 (load), 2 (mul/div):
- req[i]  in  1  write request.
- sel[i]  in  5  destination register.
- dat[i]  in  32  write data.
- gnt[i]  out  1  grant.
REQ-003 The block SHALL drive the register-file write port as follows.
- wen  out  1  write enable.
- wsel  out  5  write register.
- wdat  out  32  write data.
REQ-004 The block SHALL expose a pending-write mask:
- pend_mask  out  32  bit r set while a write to register r is staged.

Function
REQ-005 The block SHALL assert gnt combinationally in the same cycle as the winning req, to at most one requester per cycle (one-hot or zero).
REQ-006 A requester SHALL hold req, sel and dat stable until it samples gnt=1; the transfer completes on the clock edge where req=1 and gnt=1.
REQ-007 The block SHALL never assert gnt[i] while req[i]=0; if any req is 1, exactly one gnt SHALL be 1 (work-conserving).
REQ-008 The granted sel/dat SHALL be captured into a staging register on the grant edge and driven on wsel/wdat with wen=1 for exactly the following cycle (latency 1).
REQ-009 With no grant in a cycle, wen SHALL be 0 in the next cycle, and wsel/wdat SHALL hold their previous values.
REQ-010 A granted request with sel=0 SHALL be consumed (gnt=1) but SHALL stage wen=0, with x0 never written.
REQ-011 pend_mask SHALL equal (1<<wsel) when wen=1, and 0 otherwise; bit 0 SHALL always be 0.
REQ-012 The arbitration state SHALL be a 2-bit priority pointer ptr in {0,1,2}; the search order SHALL be ptr, ptr+1, ptr+2, all modulo 3.
REQ-013 After a grant to requester k, ptr SHALL become (k+1) mod 3; with no grant, ptr SHALL be unchanged.
REQ-014 Under continuous requests from all three requesters, each requester SHALL be granted once every 3 cycles (no starvation).
REQ-015 ptr value 3 SHALL be unreachable; if it is ever observed, it SHALL be treated as 0.
REQ-016 The block SHALL not deassert a grant mid-cycle based on anything other than req or ptr.

Reset
REQ-017 While rst=1, the block SHALL force gnt=0, wen=0, wsel=0, wdat=0, pend_mask=0 and ptr=0, asynchronously.
REQ-018 Reset asserted mid-transfer SHALL drop the staged write, which is not written.
REQ-019 A requester holding req across a reset SHALL be re-arbitrated from ptr=0 after rst deasserts.
REQ-020 Grants SHALL be possible in the first cycle with rst=0.

Configuration
REQ-021 With macro WB_ROUND_ROBIN_EN defined, arbitration SHALL follow REQ-012 to REQ-015.
REQ-022 With WB_ROUND_ROBIN_EN undefined, arbitration SHALL be fixed priority 0 > 1 > 2, the ptr register SHALL not exist, and REQ-014 SHALL not apply; all other requirements SHALL hold.

Verification
REQ-023 Reset check: hold rst=1 with all req=1 -> gnt=000, wen=0, pend_mask=0; release rst -> gnt=001 in the first cycle.
REQ-024 Single write: req[1]=1, sel=5, dat=0xDEADBEEF for 1 cycle -> gnt[1]=1 that cycle; next cycle wen=1, wsel=5, wdat=0xDEADBEEF, pend_mask=0x00000020; the cycle after, wen=0.
REQ-025 Round-robin (WB_ROUND_ROBIN_EN defined): all req held high for 6 cycles -> grant sequence 0,1,2,0,1,2, and wen=1 in every cycle from the 2nd onward.
REQ-026 Fixed priority (WB_ROUND_ROBIN_EN undefined): all req held high -> gnt[0] every cycle; when req0 drops, gnt[1] every cycle.
REQ-027 x0 drop: req[2]=1 with sel=0, dat=0x1234 -> gnt[2]=1; next cycle wen=0 and pend_mask=0.
REQ-028 Reset mid-operation: rst pulsed 1 cycle after the grant of sel=7 -> wen never 1 for sel 7; ptr=0 after the release.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: three requesters share one register-file write port via a 1-cycle staging
// register. Define WB_ROUND_ROBIN_EN for round-robin arbitration; otherwise fixed priority 0>1>2.
module rf_wb_arbiter (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       req,
  input  logic [2:0][4:0]  sel,
  input  logic [2:0][31:0] dat,
  output logic [2:0]       gnt,
  output logic             wen,
  output logic [4:0]       wsel,
  output logic [31:0]      wdat,
  output logic [31:0]      pend_mask
);

  logic [1:0]  win;
  logic        any_req;
  logic        grant_vld;
  logic [4:0]  win_sel;
  logic [31:0] win_dat;

  logic        wen_q;
  logic [4:0]  wsel_q;
  logic [31:0] wdat_q;

  assign any_req = |req;

`ifdef WB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic [1:0] ptr_eff;
  logic [1:0] c0, c1, c2;

  always_comb begin
    // Encoding 3 is never produced; fold it onto 0 should it ever appear.
    ptr_eff = (ptr_q == 2'd3) ? 2'd0 : ptr_q;
    c0 = 2'd0;
    c1 = 2'd1;
    c2 = 2'd2;
    unique case (ptr_eff)
      2'd1: begin
        c0 = 2'd1;
        c1 = 2'd2;
        c2 = 2'd0;
      end
      2'd2: begin
        c0 = 2'd2;
        c1 = 2'd0;
        c2 = 2'd1;
      end
      default: begin
        c0 = 2'd0;
        c1 = 2'd1;
        c2 = 2'd2;
      end
    endcase

    if (req[c0]) begin
      win = c0;
    end else if (req[c1]) begin
      win = c1;
    end else begin
      win = c2;
    end

    if (any_req) begin
      ptr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
    end else begin
      ptr_d = ptr_eff;
    end
  end
`else
  always_comb begin
    if (req[0]) begin
      win = 2'd0;
    end else if (req[1]) begin
      win = 2'd1;
    end else begin
      win = 2'd2;
    end
  end
`endif

  assign grant_vld = any_req & ~rst;

  always_comb begin
    gnt     = 3'b000;
    win_sel = sel[0];
    win_dat = dat[0];
    unique case (win)
      2'd1: begin
        win_sel = sel[1];
        win_dat = dat[1];
      end
      2'd2: begin
        win_sel = sel[2];
        win_dat = dat[2];
      end
      default: begin
        win_sel = sel[0];
        win_dat = dat[0];
      end
    endcase
    if (grant_vld) begin
      gnt = 3'b001 << win;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q  <= 1'b0;
      wsel_q <= 5'd0;
      wdat_q <= 32'd0;
`ifdef WB_ROUND_ROBIN_EN
      ptr_q  <= 2'd0;
`endif
    end else begin
      if (any_req) begin
        // A grant to x0 is consumed but never becomes a write.
        wen_q  <= (win_sel != 5'd0);
        wsel_q <= win_sel;
        wdat_q <= win_dat;
      end else begin
        wen_q  <= 1'b0;
      end
`ifdef WB_ROUND_ROBIN_EN
      ptr_q <= ptr_d;
`endif
    end
  end

  assign wen       = wen_q;
  assign wsel      = wsel_q;
  assign wdat      = wdat_q;
  assign pend_mask = wen_q ? (32'd1 << wsel_q) : 32'd0;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: grants are checked in-cycle, staged writes go through a
// scoreboard queue and are compared one cycle later.
module tb_rf_wb_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       req;
  logic [2:0][4:0]  sel;
  logic [2:0][31:0] dat;
  logic [2:0]       gnt;
  logic             wen;
  logic [4:0]       wsel;
  logic [31:0]      wdat;
  logic [31:0]      pend_mask;

  typedef struct {
    logic        wen;
    logic [4:0]  wsel;
    logic [31:0] wdat;
  } exp_t;

  exp_t        sb[$];
  logic [4:0]  mdl_wsel;
  logic [31:0] mdl_wdat;
  int          tests  = 0;
  int          failed = 0;

  rf_wb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .dat       (dat),
    .gnt       (gnt),
    .wen       (wen),
    .wsel      (wsel),
    .wdat      (wdat),
    .pend_mask (pend_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s: got %h, want %h", tag, obs, expv);
    end
  endtask

  // One arbitration cycle: check grant mid-cycle, predict the staged write, compare after the edge.
  task automatic cycle(input string tag, input logic [2:0] exp_gnt);
    exp_t e;
    int   k;
    #1;
    check({tag, ".gnt"}, {29'd0, gnt}, {29'd0, exp_gnt});
    e.wen  = 1'b0;
    e.wsel = mdl_wsel;
    e.wdat = mdl_wdat;
    if (exp_gnt != 3'b000) begin
      k = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
      mdl_wsel = sel[k];
      mdl_wdat = dat[k];
      e.wen  = (sel[k] != 5'd0);
      e.wsel = sel[k];
      e.wdat = dat[k];
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".wen"},  {31'd0, wen}, {31'd0, e.wen});
    check({tag, ".wsel"}, {27'd0, wsel}, {27'd0, e.wsel});
    check({tag, ".wdat"}, wdat, e.wdat);
    check({tag, ".pend"}, pend_mask, e.wen ? (32'd1 << e.wsel) : 32'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst    = 1'b1;
    req    = 3'b111;
    sel[0] = 5'd1;
    sel[1] = 5'd2;
    sel[2] = 5'd3;
    dat[0] = 32'hA000_0001;
    dat[1] = 32'hB000_0002;
    dat[2] = 32'hC000_0003;
    mdl_wsel = 5'd0;
    mdl_wdat = 32'd0;

    // Reset held with every requester active.
    #2;
    check("rst.gnt",  {29'd0, gnt}, 32'd0);
    check("rst.wen",  {31'd0, wen}, 32'd0);
    check("rst.pend", pend_mask, 32'd0);
    @(posedge clk);
    #1;
    check("rst.wsel", {27'd0, wsel}, 32'd0);
    check("rst.wdat", wdat, 32'd0);
    check("rst.gnt2", {29'd0, gnt}, 32'd0);
    rst = 1'b0;
    cycle("first", 3'b001);

    // Single write from the load port.
    req    = 3'b010;
    sel[1] = 5'd5;
    dat[1] = 32'hDEAD_BEEF;
    cycle("single", 3'b010);
    req = 3'b000;
    cycle("idle", 3'b000);

    // Write to x0 is consumed but dropped.
    req    = 3'b100;
    sel[2] = 5'd0;
    dat[2] = 32'h0000_1234;
    cycle("x0", 3'b100);
    req = 3'b000;
    cycle("x0idle", 3'b000);

    sel[1] = 5'd2;
    sel[2] = 5'd3;
    dat[1] = 32'hB000_0002;
    dat[2] = 32'hC000_0003;
    req    = 3'b111;
`ifdef WB_ROUND_ROBIN_EN
    cycle("rr0", 3'b001);
    cycle("rr1", 3'b010);
    cycle("rr2", 3'b100);
    cycle("rr3", 3'b001);
    cycle("rr4", 3'b010);
    cycle("rr5", 3'b100);
`else
    cycle("fp0", 3'b001);
    cycle("fp1", 3'b001);
    cycle("fp2", 3'b001);
    req = 3'b110;
    cycle("fp3", 3'b010);
    cycle("fp4", 3'b010);
`endif

    // Move the pointer off zero before the reset test.
    req    = 3'b001;
    sel[0] = 5'd4;
    dat[0] = 32'h4444_4444;
    cycle("pre", 3'b001);

    // Reset during a transfer to x7: the staged write must vanish.
    req    = 3'b010;
    sel[1] = 5'd7;
    dat[1] = 32'h0000_0077;
    #1;
    check("mid.gnt", {29'd0, gnt}, 32'd2);
    rst = 1'b1;
    #1;
    check("mid.rgnt", {29'd0, gnt}, 32'd0);
    check("mid.wen",  {31'd0, wen}, 32'd0);
    @(posedge clk);
    #1;
    check("mid.wen2", {31'd0, wen}, 32'd0);
    check("mid.pend", pend_mask, 32'd0);
    rst = 1'b0;
    mdl_wsel = 5'd0;
    mdl_wdat = 32'd0;
    check("mid.wsel", {27'd0, wsel}, 32'd0);
    check("mid.wdat", wdat, 32'd0);

    // Requesters still asserted re-arbitrate from pointer 0.
    req    = 3'b111;
    sel[1] = 5'd6;
    dat[1] = 32'h6666_6666;
    cycle("post0", 3'b001);
`ifdef WB_ROUND_ROBIN_EN
    cycle("post1", 3'b010);
`else
    cycle("post1", 3'b001);
`endif
    req = 3'b000;
    cycle("end", 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
